hazard_unit_mc: RTL

- Parametrised hazard control unit for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB); replaces the single-cycle hazard block.
- Provides MEM/WB forwarding select, load-use stall, branch/jump flush of ID and EX, and a sequential stall FSM for multi-cycle EX operations (MUL/DIV) of latency MC_LAT.
- Adds saturating performance counters for stall cycles and taken redirects.
- Sits beside the pipeline registers; all stall and flush outputs drive their enables and clears directly.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_unit_mc_sat_counter.sv | 30 +++
 rtl/hazard_unit_mc.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_unit_mc_sat_counter.sv
// Saturating up-counter: counts cycles with inc_i high and holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard control for the 5-stage pipeline: forwarding, load-use, redirect flush,
// multi-cycle EX stall sequencing and saturating performance counters.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REGN_W = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_MEM,
  input  logic              RegWrite_WB,
  input  logic [REGN_W-1:0] registerNumber1_exec,
  input  logic [REGN_W-1:0] registerNumber2_exec,
  input  logic [REGN_W-1:0] rdn_MEM,
  input  logic [REGN_W-1:0] rdn_WB,
  input  logic [REGN_W-1:0] rdn_exec,
  input  logic [REGN_W-1:0] rs1n_instrDecode,
  input  logic [REGN_W-1:0] rs2n_instrDecode,
  input  logic              rs1Used_instrDecode,
  input  logic              rs2Used_instrDecode,
  input  logic              MemToReg_exec,
  input  logic              MultiCycle_exec,
  input  logic              Jump_exec,
  input  logic              Branch_exec,
  input  logic              InvertBranchTriger_exec,
  input  logic [XLEN-1:0]   ALUOut_exec,
  output logic [1:0]        ForwardSrc1_exec,
  output logic [1:0]        ForwardSrc2_exec,
  output logic              Stall_instrFetch,
  output logic              Stall_instrDecode,
  output logic              Stall_exec,
  output logic              Flush_instrDecode,
  output logic              Flush_exec,
  output logic              Flush_MEM,
  output logic              BranchIsTaken_exec,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  RedirectCount
);

  logic load_use;
  logic mc_stall;

  // MEM holds the younger result, so it wins over WB; x0 is hard-wired zero.
  always_comb begin
    ForwardSrc1_exec = FWD_RF;
    ForwardSrc2_exec = FWD_RF;
    if (registerNumber1_exec != '0) begin
      if (RegWrite_MEM && (rdn_MEM == registerNumber1_exec)) begin
        ForwardSrc1_exec = FWD_MEM;
      end else if (RegWrite_WB && (rdn_WB == registerNumber1_exec)) begin
        ForwardSrc1_exec = FWD_WB;
      end
    end
    if (registerNumber2_exec != '0) begin
      if (RegWrite_MEM && (rdn_MEM == registerNumber2_exec)) begin
        ForwardSrc2_exec = FWD_MEM;
      end else if (RegWrite_WB && (rdn_WB == registerNumber2_exec)) begin
        ForwardSrc2_exec = FWD_WB;
      end
    end
  end

  assign BranchIsTaken_exec = Jump_exec |
                              (Branch_exec & (InvertBranchTriger_exec ^ (ALUOut_exec != '0)));

  assign load_use = MemToReg_exec && (rdn_exec != '0) &&
                    ((rs1Used_instrDecode && (rs1n_instrDecode == rdn_exec)) ||
                     (rs2Used_instrDecode && (rs2n_instrDecode == rdn_exec)));

  generate
    if (MC_LAT > 1) begin : g_mc
      localparam int CW = (MC_LAT > 3) ? $clog2(MC_LAT - 2) : 1;

      mc_state_t      state_q, state_d;
      logic [CW-1:0]  cnt_q, cnt_d;
      logic           mc_start;

      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_start = (state_q == IDLE) && MultiCycle_exec;
        case (state_q)
          IDLE: begin
            if (mc_start) begin
              if (MC_LAT > 2) begin
                state_d = BUSY;
                cnt_d   = CW'(MC_LAT - 3);
              end else begin
                state_d = DONE;
              end
            end
          end
          BUSY: begin
            if (cnt_q == '0) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          // DONE lets the finished op leave EX without re-triggering itself.
          DONE:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign mc_stall = mc_start | (state_q == BUSY);
    end else begin : g_no_mc
      assign mc_stall = 1'b0;
    end
  endgenerate

  always_comb begin
    Stall_instrFetch  = 1'b0;
    Stall_instrDecode = 1'b0;
    Stall_exec        = 1'b0;
    Flush_instrDecode = 1'b0;
    Flush_exec        = 1'b0;
    Flush_MEM         = 1'b0;
    if (BranchIsTaken_exec) begin
      Flush_instrDecode = 1'b1;
      Flush_exec        = 1'b1;
    end else if (mc_stall) begin
      Stall_instrFetch  = 1'b1;
      Stall_instrDecode = 1'b1;
      Stall_exec        = 1'b1;
      Flush_MEM         = 1'b1;
    end else if (load_use) begin
      Stall_instrFetch  = 1'b1;
      Stall_instrDecode = 1'b1;
      Flush_exec        = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (Stall_instrFetch),
    .count_o (StallCycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (BranchIsTaken_exec),
    .count_o (RedirectCount)
  );

endmodule
